// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA horizontal and vertical timing generator.
//
// A pixel/line counter pair that advances once per pixel tick (pix_en)
// and produces sync, blanking and end-of-line/end-of-frame strobes.
//
// Ports:
//   clk       in   system clock; all state changes on its rising edge
//   rst       in   synchronous active-high reset (has priority over pix_en)
//   pix_en    in   pixel tick; counters advance only when this is 1
//   hcount    out  current pixel column  [CW-1:0]
//   vcount    out  current line          [CW-1:0]
//   hsync     out  horizontal sync, active level set by HS_POL
//   vsync     out  vertical sync, active level set by VS_POL
//   video_on  out  1 while (hcount, vcount) is inside the visible area
//   line_end  out  one-tick strobe on the last pixel of every line
//   frame_end out  one-tick strobe on the last pixel of every frame
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_end,
    output logic          frame_end
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    // The counters must be able to hold every position up to TOTAL-1.
    generate
        if ((64'd1 << CW) < 64'(MAX_TOTAL)) begin : g_cw_too_small
            $error("vga_timing_gen: CW=%0d cannot hold a count of %0d", CW, MAX_TOTAL);
        end
    endgenerate

    // All boundaries pre-sized to CW bits so every comparison is same-width.
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);

    logic [CW-1:0] hcount_reg, hcount_next;
    logic [CW-1:0] vcount_reg, vcount_next;
    logic          hsync_reg, hsync_next;
    logic          vsync_reg, vsync_next;
    logic          video_on_reg, video_on_next;
    logic          h_wrap;
    logic          v_wrap;

    assign h_wrap = (hcount_reg == H_LAST);
    assign v_wrap = (vcount_reg == V_LAST);

    // Next-count logic. When pix_en is low the next values equal the
    // current ones, so the derived outputs below also hold.
    always_comb begin
        hcount_next = hcount_reg;
        vcount_next = vcount_reg;
        if (pix_en) begin
            if (h_wrap) begin
                hcount_next = '0;
                vcount_next = v_wrap ? '0 : (vcount_reg + ONE);
            end else begin
                hcount_next = hcount_reg + ONE;
            end
        end
    end

    // Sync and blanking are decoded from the next counts and registered,
    // so they change on the same edge as the counters (no lag, no glitches).
    always_comb begin
        hsync_next    = ((hcount_next >= HS_FIRST) && (hcount_next <= HS_LAST)) ? HS_ON : ~HS_ON;
        vsync_next    = ((vcount_next >= VS_FIRST) && (vcount_next <= VS_LAST)) ? VS_ON : ~VS_ON;
        video_on_next = (hcount_next < H_VIS) && (vcount_next < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_reg   <= '0;
            vcount_reg   <= '0;
            hsync_reg    <= ~HS_ON;
            vsync_reg    <= ~VS_ON;
            video_on_reg <= 1'b1;   // (0,0) is always a visible pixel
        end else begin
            hcount_reg   <= hcount_next;
            vcount_reg   <= vcount_next;
            hsync_reg    <= hsync_next;
            vsync_reg    <= vsync_next;
            video_on_reg <= video_on_next;
        end
    end

    assign hcount   = hcount_reg;
    assign vcount   = vcount_reg;
    assign hsync    = hsync_reg;
    assign vsync    = vsync_reg;
    assign video_on = video_on_reg;

    // Strobes are combinational so they last exactly one clk: they mark the
    // edge on which the counters will wrap, and are suppressed during reset.
    assign line_end  = pix_en & ~rst & h_wrap;
    assign frame_end = line_end & v_wrap;

endmodule
